// File: rtl/zube_fifo_bridge_if.sv
// rtl/zube_fifo_bridge_if.sv - Wishbone register bus between the SoC and the Z80 FIFO bridge
interface zube_fifo_bridge_if;
    logic        wb_cyc_in;
    logic        wb_stb_in;
    logic        wb_we_in;
    logic [31:0] wb_addr_in;
    logic [31:0] wb_data_in;
    logic        wb_ack_out;
    logic [31:0] wb_data_out;

    modport master (
        output wb_cyc_in, wb_stb_in, wb_we_in, wb_addr_in, wb_data_in,
        input  wb_ack_out, wb_data_out
    );

    modport slave (
        input  wb_cyc_in, wb_stb_in, wb_we_in, wb_addr_in, wb_data_in,
        output wb_ack_out, wb_data_out
    );
endinterface

// File: rtl/zube_fifo_bridge.sv
// rtl/zube_fifo_bridge.sv - Z80 I/O port to Wishbone bridge with one byte FIFO per direction
module zube_fifo_bridge #(
    parameter logic [31:0] BASE_ADDRESS   = 32'h3000_0000,
    parameter int          DEPTH_LOG2     = 4,
    parameter logic [7:0]  Z80_BASE_RESET = 8'h80
) (
    input  logic               clk,
    input  logic               reset_b,
    input  logic               z80_write_strobe_b,
    input  logic               z80_read_strobe_b,
    input  logic [7:0]         z80_address_bus,
    input  logic [7:0]         z80_data_bus_in,
    output logic [7:0]         z80_data_bus_out,
    output logic               z80_bus_dir,
    zube_fifo_bridge_if.slave  wb,
    output logic               irq_out
);
    localparam int          DEPTH     = 1 << DEPTH_LOG2;
    localparam int          CW        = DEPTH_LOG2 + 1;
    localparam logic [31:0] ADDR_BASE = BASE_ADDRESS;
    localparam logic [31:0] ADDR_DATA = BASE_ADDRESS + 32'd4;
    localparam logic [31:0] ADDR_STAT = BASE_ADDRESS + 32'd8;
    localparam logic [31:0] ADDR_IRQ  = BASE_ADDRESS + 32'd12;

    logic [1:0]            wr_sync, rd_sync;
    logic [7:0]            addr_meta, addr_sync, data_meta, data_sync;
    logic [1:0]            settle;
    logic                  wr_live, rd_live, wr_prev, rd_prev;
    logic [7:0]            wr_addr_lat, wr_data_lat;
    logic                  wr_b, rd_b, wr_rise, rd_fall, rd_rise, rd_pending;

    logic [7:0]            z80_base, z80_base_p1;
    logic [2:0]            irq_en;
    logic [3:0]            flags, flag_set, flag_clr;

    logic [7:0]            rx_mem [DEPTH];
    logic [7:0]            tx_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] rx_wr_ptr, rx_rd_ptr, tx_wr_ptr, tx_rd_ptr;
    logic [CW-1:0]         rx_cnt, tx_cnt;
    logic                  rx_full, rx_empty, tx_full, tx_empty;
    logic                  rx_push, rx_pop, tx_push, tx_pop;
    logic                  rx_push_ok, rx_pop_ok, tx_push_ok, tx_pop_ok;

    logic                  sel_base, sel_data, sel_stat, sel_irq, wb_acc;
    logic [31:0]           rd_data;
    logic                  unused_wb_bits;

    assign unused_wb_bits = ^{wb.wb_data_in[31:16], wb.wb_data_in[11:8]};

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            wr_sync   <= 2'b11;
            rd_sync   <= 2'b11;
            addr_meta <= '0;
            addr_sync <= '0;
            data_meta <= '0;
            data_sync <= '0;
        end else begin
            wr_sync   <= {wr_sync[0], z80_write_strobe_b};
            rd_sync   <= {rd_sync[0], z80_read_strobe_b};
            addr_meta <= z80_address_bus;
            addr_sync <= addr_meta;
            data_meta <= z80_data_bus_in;
            data_sync <= data_meta;
        end
    end

    assign wr_b = wr_sync[1];
    assign rd_b = rd_sync[1];

    // Edges only count once a strobe has been seen idle after the synchroniser has flushed,
    // so a strobe held low across reset release cannot fake a transfer.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            settle      <= 2'b00;
            wr_live     <= 1'b0;
            rd_live     <= 1'b0;
            wr_prev     <= 1'b1;
            rd_prev     <= 1'b1;
            wr_addr_lat <= '0;
            wr_data_lat <= '0;
        end else begin
            settle  <= {settle[0], 1'b1};
            wr_prev <= wr_b;
            rd_prev <= rd_b;
            if (settle[1] && wr_b) wr_live <= 1'b1;
            if (settle[1] && rd_b) rd_live <= 1'b1;
            if (!wr_b) begin
                wr_addr_lat <= addr_sync;
                wr_data_lat <= data_sync;
            end
        end
    end

    assign wr_rise     = wr_live & ~wr_prev & wr_b;
    assign rd_fall     = rd_live & rd_prev & ~rd_b;
    assign rd_rise     = rd_live & ~rd_prev & rd_b;
    assign z80_base_p1 = z80_base + 8'd1;

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            z80_data_bus_out <= 8'h00;
            z80_bus_dir      <= 1'b0;
            rd_pending       <= 1'b0;
        end else if (rd_fall) begin
            if (addr_sync == z80_base) begin
                z80_data_bus_out <= tx_empty ? 8'hFF : tx_mem[tx_rd_ptr];
                z80_bus_dir      <= 1'b1;
                rd_pending       <= 1'b1;
            end else if (addr_sync == z80_base_p1) begin
                z80_data_bus_out <= {6'b0, ~rx_full, ~tx_empty};
                z80_bus_dir      <= 1'b1;
            end
        end else if (rd_rise) begin
            z80_bus_dir <= 1'b0;
            rd_pending  <= 1'b0;
        end
    end

    assign sel_base = (wb.wb_addr_in == ADDR_BASE);
    assign sel_data = (wb.wb_addr_in == ADDR_DATA);
    assign sel_stat = (wb.wb_addr_in == ADDR_STAT);
    assign sel_irq  = (wb.wb_addr_in == ADDR_IRQ);
    assign wb_acc   = wb.wb_cyc_in & wb.wb_stb_in & ~wb.wb_ack_out
                    & (sel_base | sel_data | sel_stat | sel_irq);

    assign rx_push = wr_rise & (wr_addr_lat == z80_base);
    assign rx_pop  = wb_acc & ~wb.wb_we_in & sel_data;
    assign tx_push = wb_acc & wb.wb_we_in & sel_data;
    assign tx_pop  = rd_rise & rd_pending;

    assign rx_full    = rx_cnt[DEPTH_LOG2];
    assign tx_full    = tx_cnt[DEPTH_LOG2];
    assign rx_empty   = (rx_cnt == '0);
    assign tx_empty   = (tx_cnt == '0);
    assign rx_push_ok = rx_push & ~rx_full;
    assign rx_pop_ok  = rx_pop & ~rx_empty;
    assign tx_push_ok = tx_push & ~tx_full;
    assign tx_pop_ok  = tx_pop & ~tx_empty;

    always_ff @(posedge clk) begin
        if (rx_push_ok) rx_mem[rx_wr_ptr] <= wr_data_lat;
        if (tx_push_ok) tx_mem[tx_wr_ptr] <= wb.wb_data_in[7:0];
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_cnt    <= '0;
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_cnt    <= '0;
        end else begin
            if (rx_push_ok) rx_wr_ptr <= rx_wr_ptr + 1'b1;
            if (rx_pop_ok)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
            if (tx_push_ok) tx_wr_ptr <= tx_wr_ptr + 1'b1;
            if (tx_pop_ok)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
            rx_cnt <= rx_cnt + CW'(rx_push_ok) - CW'(rx_pop_ok);
            tx_cnt <= tx_cnt + CW'(tx_push_ok) - CW'(tx_pop_ok);
        end
    end

    // Flag order matches STATUS[15:12]: rx_ovf, rx_unf, tx_ovf, tx_unf.
    assign flag_set = {rx_push & rx_full, rx_pop & rx_empty, tx_push & tx_full, tx_pop & tx_empty};
    assign flag_clr = (wb_acc & wb.wb_we_in & sel_irq) ? wb.wb_data_in[15:12] : 4'b0000;

    always_comb begin
        rd_data = '0;
        if (sel_base) begin
            rd_data[7:0] = z80_base;
        end else if (sel_data) begin
            rd_data[7:0] = rx_empty ? 8'h00 : rx_mem[rx_rd_ptr];
        end else if (sel_stat) begin
            rd_data[16 +: CW] = rx_cnt;
            rd_data[15:12]    = flags;
            rd_data[0 +: CW]  = tx_cnt;
        end else if (sel_irq) begin
            rd_data[2:0] = irq_en;
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            z80_base       <= Z80_BASE_RESET;
            irq_en         <= 3'b000;
            flags          <= 4'b0000;
            wb.wb_ack_out  <= 1'b0;
            wb.wb_data_out <= '0;
            irq_out        <= 1'b0;
        end else begin
            wb.wb_ack_out <= wb_acc;
            flags         <= (flags & ~flag_clr) | flag_set;
            if (wb_acc && !wb.wb_we_in) wb.wb_data_out <= rd_data;
            if (wb_acc && wb.wb_we_in && sel_base) z80_base <= wb.wb_data_in[7:0];
            if (wb_acc && wb.wb_we_in && sel_irq) irq_en <= wb.wb_data_in[2:0];
            irq_out <= (irq_en[0] & ~rx_empty) | (irq_en[1] & tx_empty) | (irq_en[2] & (|flags));
        end
    end
endmodule

// File: tb/tb_zube_fifo_bridge.sv
// tb/tb_zube_fifo_bridge.sv - scoreboard bench for zube_fifo_bridge against a queue model
module tb_zube_fifo_bridge;
    localparam logic [31:0] BASE  = 32'h3000_0000;
    localparam int          DL2   = 2;
    localparam int          DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset_b = 1'b0;
    logic       z80_write_strobe_b = 1'b1;
    logic       z80_read_strobe_b = 1'b1;
    logic [7:0] z80_address_bus = 8'h00;
    logic [7:0] z80_data_bus_in = 8'h00;
    logic [7:0] z80_data_bus_out;
    logic       z80_bus_dir;
    logic       irq_out;

    zube_fifo_bridge_if wb_bus ();

    zube_fifo_bridge #(
        .BASE_ADDRESS  (BASE),
        .DEPTH_LOG2    (DL2),
        .Z80_BASE_RESET(8'h80)
    ) dut (
        .clk               (clk),
        .reset_b           (reset_b),
        .z80_write_strobe_b(z80_write_strobe_b),
        .z80_read_strobe_b (z80_read_strobe_b),
        .z80_address_bus   (z80_address_bus),
        .z80_data_bus_in   (z80_data_bus_in),
        .z80_data_bus_out  (z80_data_bus_out),
        .z80_bus_dir       (z80_bus_dir),
        .wb                (wb_bus),
        .irq_out           (irq_out)
    );

    always #5 clk = ~clk;

    // reference model
    logic [7:0]  rxq[$];
    logic [7:0]  txq[$];
    logic [3:0]  m_flags = 4'h0;
    logic [2:0]  m_en = 3'b000;
    logic [7:0]  m_base = 8'h80;

    // scoreboard queues
    logic        wbq_chk[$];
    logic [31:0] wbq_data[$];
    logic [7:0]  zq[$];

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] status_exp();
        return (32'(rxq.size()) << 16) | (32'(m_flags) << 12) | 32'(txq.size());
    endfunction

    function automatic logic model_irq();
        return (m_en[0] && rxq.size() != 0) || (m_en[1] && txq.size() == 0) || (m_en[2] && m_flags != 4'h0);
    endfunction

    // monitor: pops expectations whenever the DUT acks or turns the Z80 bus around
    logic prev_ack = 1'b0;
    logic prev_dir = 1'b0;
    always @(negedge clk) begin
        logic        c;
        logic [31:0] d;
        logic [7:0]  z;
        if (wb_bus.wb_ack_out) begin
            check("ack_single_cycle", 32'(prev_ack), 32'd0);
            if (wbq_chk.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_ack: got ack with addr %08h expected none", wb_bus.wb_addr_in);
            end else begin
                c = wbq_chk.pop_front();
                d = wbq_data.pop_front();
                if (c) check("wb_rdata", wb_bus.wb_data_out, d);
            end
        end
        if (z80_bus_dir && !prev_dir) begin
            if (zq.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_bus_dir: got dir=1 expected 0");
            end else begin
                z = zq.pop_front();
                check("z80_rdata", 32'(z80_data_bus_out), 32'(z));
            end
        end
        prev_ack = wb_bus.wb_ack_out;
        prev_dir = z80_bus_dir;
    end

    task automatic wb_do(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic mapped, input logic chk, input logic [31:0] exp);
        bit got;
        @(negedge clk);
        if (mapped) begin
            wbq_chk.push_back(chk);
            wbq_data.push_back(exp);
        end
        wb_bus.wb_cyc_in  = 1'b1;
        wb_bus.wb_stb_in  = 1'b1;
        wb_bus.wb_we_in   = we;
        wb_bus.wb_addr_in = addr;
        wb_bus.wb_data_in = wdata;
        if (mapped) begin
            got = 1'b0;
            for (int i = 0; i < 8 && !got; i++) begin
                @(negedge clk);
                if (wb_bus.wb_ack_out) got = 1'b1;
            end
            check("ack_seen", 32'(got), 32'd1);
        end else begin
            repeat (5) @(negedge clk);
        end
        wb_bus.wb_cyc_in = 1'b0;
        wb_bus.wb_stb_in = 1'b0;
        wb_bus.wb_we_in  = 1'b0;
    endtask

    task automatic wb_write_data(input logic [7:0] d);
        if (txq.size() == DEPTH) m_flags[1] = 1'b1;
        else txq.push_back(d);
        wb_do(1'b1, BASE + 32'd4, {24'hABCDEF, d}, 1'b1, 1'b0, 32'd0);
    endtask

    task automatic wb_read_data();
        logic [31:0] e;
        if (rxq.size() != 0) e = 32'(rxq.pop_front());
        else begin
            e = 32'd0;
            m_flags[2] = 1'b1;
        end
        wb_do(1'b0, BASE + 32'd4, 32'd0, 1'b1, 1'b1, e);
    endtask

    task automatic wb_read_status();
        wb_do(1'b0, BASE + 32'd8, 32'd0, 1'b1, 1'b1, status_exp());
    endtask

    task automatic wb_write_irq(input logic [31:0] d);
        m_en    = d[2:0];
        m_flags = m_flags & ~d[15:12];
        wb_do(1'b1, BASE + 32'd12, d, 1'b1, 1'b0, 32'd0);
    endtask

    task automatic wb_read_irq();
        wb_do(1'b0, BASE + 32'd12, 32'd0, 1'b1, 1'b1, 32'(m_en));
    endtask

    task automatic wb_write_base(input logic [31:0] d);
        m_base = d[7:0];
        wb_do(1'b1, BASE, d, 1'b1, 1'b0, 32'd0);
    endtask

    task automatic wb_read_base();
        wb_do(1'b0, BASE, 32'd0, 1'b1, 1'b1, 32'(m_base));
    endtask

    task automatic z80_write(input logic [7:0] a, input logic [7:0] d);
        if (a == m_base) begin
            if (rxq.size() == DEPTH) m_flags[3] = 1'b1;
            else rxq.push_back(d);
        end
        @(negedge clk);
        z80_address_bus    = a;
        z80_data_bus_in    = d;
        z80_write_strobe_b = 1'b0;
        repeat (4) @(negedge clk);
        z80_write_strobe_b = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic z80_read(input logic [7:0] a);
        logic [7:0] b1;
        logic       mapped;
        b1     = m_base + 8'd1;
        mapped = (a == m_base) || (a == b1);
        if (a == m_base) zq.push_back(txq.size() != 0 ? txq[0] : 8'hFF);
        else if (a == b1) zq.push_back({6'b0, rxq.size() != DEPTH, txq.size() != 0});
        @(negedge clk);
        z80_address_bus   = a;
        z80_read_strobe_b = 1'b0;
        repeat (5) @(negedge clk);
        check("z80_dir_during", 32'(z80_bus_dir), 32'(mapped));
        z80_read_strobe_b = 1'b1;
        if (a == m_base) begin
            if (txq.size() != 0) void'(txq.pop_front());
            else m_flags[0] = 1'b1;
        end
        repeat (5) @(negedge clk);
        check("z80_dir_after", 32'(z80_bus_dir), 32'd0);
    endtask

    task automatic chk_irq(input string name);
        repeat (2) @(negedge clk);
        check(name, 32'(irq_out), 32'(model_irq()));
    endtask

    function automatic logic [7:0] pick_addr();
        case ($urandom_range(0, 3))
            0, 1:    return m_base;
            2:       return m_base + 8'd1;
            default: return 8'($urandom);
        endcase
    endfunction

    task automatic model_reset();
        rxq.delete();
        txq.delete();
        m_flags = 4'h0;
        m_en    = 3'b000;
        m_base  = 8'h80;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit up;
        logic [7:0] e;
        wb_bus.wb_cyc_in  = 1'b0;
        wb_bus.wb_stb_in  = 1'b0;
        wb_bus.wb_we_in   = 1'b0;
        wb_bus.wb_addr_in = 32'd0;
        wb_bus.wb_data_in = 32'd0;

        repeat (3) @(negedge clk);
        check("rst_data_out", 32'(z80_data_bus_out), 32'd0);
        check("rst_bus_dir", 32'(z80_bus_dir), 32'd0);
        check("rst_ack", 32'(wb_bus.wb_ack_out), 32'd0);
        check("rst_wb_data", wb_bus.wb_data_out, 32'd0);
        check("rst_irq", 32'(irq_out), 32'd0);
        reset_b = 1'b1;
        repeat (3) @(negedge clk);

        wb_read_base();
        wb_read_status();
        wb_read_irq();

        // two Z80 writes then SoC drains them in order
        z80_write(8'h80, 8'h11);
        z80_write(8'h80, 8'h22);
        wb_read_status();
        wb_read_data();
        wb_read_data();
        wb_read_status();

        // SoC to Z80, then a read from the empty TXF
        wb_write_data(8'hA5);
        z80_read(8'h80);
        wb_read_status();
        z80_read(8'h80);
        wb_read_status();
        wb_write_irq(32'h0000_F000);

        // overflow at depth 4, then clear only tx_ovf
        for (int i = 0; i < 5; i++) wb_write_data(8'h50 + 8'(i));
        wb_read_status();
        wb_write_irq(32'h0000_2000);
        wb_read_status();
        for (int i = 0; i < 4; i++) z80_read(8'h80);
        z80_read(8'h81);

        // interrupt on RXF not empty
        wb_write_irq(32'h0000_0001);
        chk_irq("irq_idle");
        z80_write(8'h80, 8'h3C);
        chk_irq("irq_rx_rise");
        wb_read_data();
        chk_irq("irq_rx_fall");
        wb_write_irq(32'h0000_0002);
        chk_irq("irq_txe");
        wb_write_irq(32'h0000_0000);

        // relocated Z80 base and ignored writes to base+1 / old base
        wb_write_base(32'h0000_0040);
        wb_read_base();
        z80_write(8'h40, 8'h5A);
        z80_write(8'h41, 8'h66);
        z80_write(8'h80, 8'h77);
        wb_read_status();
        wb_read_data();
        wb_write_base(32'h0000_0080);

        // simultaneous Z80 push and SoC pop with three bytes queued
        z80_write(8'h80, 8'h31);
        z80_write(8'h80, 8'h32);
        z80_write(8'h80, 8'h33);
        @(negedge clk);
        z80_address_bus    = 8'h80;
        z80_data_bus_in    = 8'h34;
        z80_write_strobe_b = 1'b0;
        repeat (4) @(negedge clk);
        z80_write_strobe_b = 1'b1;
        @(negedge clk);
        e = rxq.pop_front();
        rxq.push_back(8'h34);
        wb_do(1'b0, BASE + 32'd4, 32'd0, 1'b1, 1'b1, 32'(e));
        repeat (4) @(negedge clk);
        wb_read_status();
        for (int i = 0; i < 3; i++) wb_read_data();

        // reset in the middle of a Z80 read
        wb_write_irq(32'h0000_0005);
        wb_write_data(8'hC3);
        @(negedge clk);
        zq.push_back(8'hC3);
        z80_address_bus   = 8'h80;
        z80_read_strobe_b = 1'b0;
        up = 1'b0;
        for (int i = 0; i < 10 && !up; i++) begin
            @(negedge clk);
            if (z80_bus_dir) up = 1'b1;
        end
        check("dir_before_reset", 32'(up), 32'd1);
        @(posedge clk);
        #2 reset_b = 1'b0;
        model_reset();
        #1 check("dir_async_reset", 32'(z80_bus_dir), 32'd0);
        @(negedge clk);
        reset_b = 1'b1;
        repeat (4) @(negedge clk);
        check("dir_low_after_release", 32'(z80_bus_dir), 32'd0);
        z80_read_strobe_b = 1'b1;
        repeat (5) @(negedge clk);
        wb_read_status();
        wb_read_irq();
        wb_read_base();

        // unmapped addresses: never acked, no side effects
        wb_do(1'b1, BASE + 32'd16, 32'h0000_00EE, 1'b0, 1'b0, 32'd0);
        wb_do(1'b0, BASE + 32'd3, 32'd0, 1'b0, 1'b0, 32'd0);
        wb_do(1'b1, BASE + 32'd5, 32'h0000_00EE, 1'b0, 1'b0, 32'd0);
        wb_read_status();

        for (int n = 0; n < 120; n++) begin
            case ($urandom_range(0, 9))
                0, 1: z80_write(pick_addr(), 8'($urandom));
                2, 3: z80_read(pick_addr());
                4:    wb_write_data(8'($urandom));
                5:    wb_read_data();
                6:    wb_read_status();
                7:    wb_write_irq($urandom & 32'h0000_F007);
                8:    chk_irq("irq_random");
                default: begin
                    if ($urandom_range(0, 3) == 0) wb_write_base($urandom);
                    else wb_read_irq();
                end
            endcase
        end
        wb_read_status();

        repeat (10) @(negedge clk);
        check("wb_queue_drained", 32'(wbq_chk.size()), 32'd0);
        check("z80_queue_drained", 32'(zq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
